// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state, result-select and forward-select encodings for hazard_ctrl
package hazard_pkg;
  localparam logic [0:0] RUN = 1'b0, MEM_WAIT = 1'b1;
  localparam logic [1:0] RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_EXT = 2'b11;
  localparam logic [1:0] FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MA = 2'b10;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: operand bypass select (rs vs MA/WB destinations, MA first, x0 never) -> sel
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] m_a3,
  input  logic [4:0] w_a3,
  input  logic       m_we,
  input  logic       w_we,
  output logic [1:0] sel
);
  always_comb
    sel = (m_we && m_a3 != 5'd0 && m_a3 == rs) ? FWD_MA :
          (w_we && w_a3 != 5'd0 && w_a3 == rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control and MA data-memory handshake (ins: stage regs, dm_ready; outs: stalls, flushes, fwd selects, dm_req, dm_err, stall_cnt)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       D_rs1,
  input  logic [4:0]       D_rs2,
  input  logic [4:0]       E_rs1,
  input  logic [4:0]       E_rs2,
  input  logic [4:0]       E_rf_a3,
  input  logic [4:0]       M_rf_a3,
  input  logic [4:0]       W_rf_a3,
  input  logic             E_we_rf,
  input  logic             M_we_rf,
  input  logic             W_we_rf,
  input  logic [1:0]       E_sel_result,
  input  logic             E_pc_src,
  input  logic             M_we_dm,
  input  logic             M_re_dm,
  input  logic             dm_ready,
  output logic             dm_req,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             D_flush,
  output logic             E_flush,
  output logic             W_flush,
  output logic [1:0]       E_fwd_a,
  output logic [1:0]       E_fwd_b,
  output logic             dm_err,
  output logic [CNT_W-1:0] stall_cnt
);
  logic             state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freeze, load_use, hold;
  fwd_sel u_fwd_a (.rs(E_rs1), .m_a3(M_rf_a3), .w_a3(W_rf_a3), .m_we(M_we_rf), .w_we(W_we_rf), .sel(E_fwd_a));
  fwd_sel u_fwd_b (.rs(E_rs2), .m_a3(M_rf_a3), .w_a3(W_rf_a3), .m_we(M_we_rf), .w_we(W_we_rf), .sel(E_fwd_b));
  always_comb begin
    dm_req   = !rst && (state_q == MEM_WAIT || M_we_dm || M_re_dm);
    freeze   = dm_req && !dm_ready;
    load_use = E_sel_result == RES_MEM && E_we_rf && E_rf_a3 != 5'd0 &&
               (E_rf_a3 == D_rs1 || E_rf_a3 == D_rs2);
    hold     = !rst && !freeze && load_use && !E_pc_src;
    F_stall  = freeze || hold;
    D_stall  = freeze || hold;
    E_stall  = freeze;
    M_stall  = freeze;
    D_flush  = !freeze && E_pc_src;
    E_flush  = !freeze && (E_pc_src || load_use);
    W_flush  = freeze;
    state_d  = freeze ? MEM_WAIT : RUN;
    wait_d   = state_q == RUN ? 8'd0 : wait_q == 8'hFF ? wait_q : wait_q + 8'd1;
    err_d    = err_q || (state_q == MEM_WAIT && wait_d == 8'(MEM_TIMEOUT));
    cnt_d    = cnt_q + CNT_W'(freeze);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  assign dm_err    = err_q;
  assign stall_cnt = cnt_q;
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RISC-V core. It generates stall, flush and forwarding controls for the FE/DE, DE/EX, EX/MA and MA/WB pipeline registers. It also runs the data-memory request handshake for the MA stage, freezing the pipeline while a variable-latency memory access is outstanding. It sits beside the datapath, reading stage register addresses and control bits and driving the enables and clears of every pipeline register.

## Interface
- MEM_TIMEOUT, 255: wait cycles after which `dm_err` sets (8-bit compare).
- CNT_W, 16: width of the stall performance counter.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- D_rs1, D_rs2  in  5 each  source registers of the instruction in DE
- E_rs1, E_rs2  in  5 each  source registers of the instruction in EX
- E_rf_a3, M_rf_a3, W_rf_a3  in  5 each  destination registers in EX/MA/WB
- E_we_rf, M_we_rf, W_we_rf  in  1 each  register-file write enables in EX/MA/WB
- E_sel_result  in  2  result select in EX: 00 ALU, 01 memory, 10 PC+4, 11 ext
- E_pc_src  in  1  taken branch or jump resolved in EX
- M_we_dm, M_re_dm  in  1 each  store / load present in MA
- dm_ready  in  1  data memory completes the current access this cycle
- dm_req  out  1  data-memory access request
- F_stall, D_stall, E_stall, M_stall  out  1 each  hold PC / DE / EX / MA registers
- D_flush, E_flush, W_flush  out  1 each  synchronous clear of DE / EX / WB registers
- E_fwd_a, E_fwd_b  out  2 each  operand select: 00 RF, 01 WB result, 10 MA result
- dm_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  count of cycles with the memory freeze active

## Operation
- FSM states: RUN and MEM_WAIT.
- **RUN:**
  - `dm_req` = `M_we_dm | M_re_dm`.
  - If `dm_req & !dm_ready`, go to MEM_WAIT. The freeze is asserted in that same cycle.
  - If `dm_ready` is high, the access completes with no stall.
- **MEM_WAIT:**
  - `dm_req` is held at 1 and the freeze is asserted.
  - On `dm_ready`, the freeze drops in that cycle and the FSM returns to RUN.
- **Freeze:**
  - F, D, E and M stall all = 1, and W_flush = 1 (a bubble goes into WB).
  - D_flush and E_flush are forced to 0.
  - Load-use and branch actions are suppressed during freeze and apply once it releases, because the stage contents are unchanged.
- **Load-use** (not frozen):
  - Condition: `E_sel_result==01 & E_we_rf & E_rf_a3!=0 & (E_rf_a3==D_rs1 | E_rf_a3==D_rs2)`.
  - Action: F_stall = D_stall = 1 and E_flush = 1, inserting one bubble.
- **Branch** (not frozen): `E_pc_src` sets D_flush = E_flush = 1.
  - Branch has priority over load-use. When both are active, there are no stalls, only the two flushes.
- **Forwarding** (combinational, active even during freeze):
  - E_fwd_a = 10 if `M_we_rf & M_rf_a3!=0 & M_rf_a3==E_rs1`.
  - Otherwise 01 if the same match holds against W.
  - Otherwise 00.
  - MA takes priority over WB. E_fwd_b uses the same rule on E_rs2.
  - x0 is never forwarded.
- **Wait counter:**
  - 8-bit, cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle, saturating at 255.
  - When it equals MEM_TIMEOUT, `dm_err` sets and stays set until `rst`. The FSM keeps waiting.
- **stall_cnt:** increments on every freeze cycle and wraps modulo 2^CNT_W.

## Timing
- Reset values: FSM = RUN, wait counter = 0, dm_err = 0, stall_cnt = 0.
  - During reset, dm_req, all stall outputs and W_flush = 0.
  - Flush and forwarding outputs follow their combinational inputs, because the pipeline registers themselves are held in reset.
- All stall, flush, forward and dm_req outputs are combinational from the inputs and the current state, with zero latency. Only the FSM, the counters and dm_err are registered.
- A zero-wait access (dm_ready high in the request cycle) costs 0 stall cycles. An N-wait access costs N freeze cycles.
- Reset during MEM_WAIT:
  - The FSM returns to RUN immediately (asynchronous reset) and dm_req drops.
  - The memory side must discard the partial access.
- Back-to-back memory ops in consecutive MA cycles are each handshaked independently. There are no idle cycles between them.
- dm_ready while dm_req = 0 is ignored.

## Structure
- Shared package `hazard_pkg`:
  - FSM state encoding.
  - sel_result encodings (`RES_ALU`, `RES_MEM`, `RES_PC4`, `RES_EXT`).
  - Forward-select encodings (`FWD_RF`, `FWD_WB`, `FWD_MA`).
- One sub-module, `fwd_sel`, instanced twice (operands a and b). It holds the pure combinational forwarding priority.
- The FSM, counters and stall/flush logic stay in `hazard_ctrl`.

## Test plan
- **Forwarding:** E_rs1=5, M_rf_a3=5, M_we_rf=1, W_rf_a3=5, W_we_rf=1 -> E_fwd_a=10. Then M_we_rf=0 -> 01. With E_rs1=0 and all writers at 0 -> 00.
- **Load-use:** E_sel_result=01, E_we_rf=1, E_rf_a3=7, D_rs2=7 -> exactly one cycle with F_stall=D_stall=E_flush=1. With E_rf_a3=0 -> no stall.
- **Branch vs load-use:** E_pc_src=1 while the load-use condition is also true -> D_flush=E_flush=1 and F_stall=D_stall=0.
- **Memory wait:** M_re_dm=1 with dm_ready low for 3 cycles, then high ->
  - 3 freeze cycles with W_flush=1;
  - dm_req held for 4 cycles;
  - stall_cnt ends at 3.
  - A zero-wait load gives 0 stall cycles.
- **Timeout and reset:** MEM_TIMEOUT=4 with dm_ready held low -> dm_err=1 after the 4th MEM_WAIT cycle and stays set. Asserting rst mid-wait -> FSM in RUN, dm_req=0, dm_err=0, stall_cnt=0.
